// File: rtl/simprisc_arb_pkg.sv
// simprisc_arb_pkg: shared types and default constants for the simprisc memory arbiter
package simprisc_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;
  localparam int MAX_STARVE = 4;
  localparam int TIMEOUT_CYC = 64;
endpackage

// File: rtl/simprisc_arb_timer.sv
// simprisc_arb_timer: clearable, enabled up-counter that stops at its terminal count
module simprisc_arb_timer #(
  parameter int W  = 6,
  parameter int TC = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == W'(TC);
  always_comb cnt_d = clr_i ? '0 : en_i && !tc_o ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/simprisc_mem_arbiter.sv
// simprisc_mem_arbiter: shares one memory port between fetch and load/store,
// LS-first with a starvation override for IF and a response timeout.
module simprisc_mem_arbiter
  import simprisc_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_STARVE  = simprisc_arb_pkg::MAX_STARVE,
  parameter int TIMEOUT_CYC = simprisc_arb_pkg::TIMEOUT_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [DW/8-1:0] ls_be_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            err_o,
  output logic            busy_o
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic tmo_clr, tmo_en, tmo_tc, starve_max, own_ls;
  simprisc_arb_timer #(.W(TW), .TC(TIMEOUT_CYC - 1)) u_tmo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(tmo_clr),
    .en_i (tmo_en),
    .tc_o (tmo_tc)
  );
  assign starve_max = starve_q == SW'(MAX_STARVE);
  assign own_ls     = owner_q == OWN_LS;
  assign busy_o     = state_q != ARB_IDLE;
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_gnt_o    = 1'b0;
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    // any response arriving while no transaction is waiting is dropped and flagged
    err_o       = mem_rvalid_i && state_q != ARB_WAIT;
    case (state_q)
      ARB_IDLE: if (if_req_i || ls_req_i) begin
        owner_d  = ls_req_i && !(if_req_i && starve_max) ? OWN_LS : OWN_IF;
        starve_d = owner_d == OWN_IF ? '0 : if_req_i && !starve_max ? starve_q + 1'b1 : starve_q;
        state_d  = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = own_ls && ls_we_i;
        mem_be_o    = own_ls ? ls_be_i : '1;
        mem_addr_o  = own_ls ? ls_addr_i : if_addr_i;
        mem_wdata_o = own_ls ? ls_wdata_i : '0;
        if (mem_gnt_i) begin
          if_gnt_o = !own_ls;
          ls_gnt_o = own_ls;
          tmo_clr  = 1'b1;
          state_d  = ARB_WAIT;
        end
      end
      ARB_WAIT: if (mem_rvalid_i || tmo_tc) begin
        if_rvalid_o = !own_ls;
        ls_rvalid_o = own_ls;
        if_rdata_o  = !own_ls && mem_rvalid_i ? mem_rdata_i : '0;
        ls_rdata_o  = own_ls && mem_rvalid_i ? mem_rdata_i : '0;
        err_o       = !mem_rvalid_i;
        state_d     = ARB_IDLE;
      end else tmo_en = 1'b1;
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
endmodule

// File: tb/tb_simprisc_mem_arbiter.sv
// tb_simprisc_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model built from cycle numbers of accept, grant and response.
module tb_simprisc_mem_arbiter;
  localparam int AW = 32, DW = 32, BW = DW / 8, MS = 4, TO = 64;
  logic clk = 1'b0, rst_n = 1'b1;
  logic if_req_i, ls_req_i, ls_we_i, mem_gnt_i, mem_rvalid_i;
  logic [AW-1:0] if_addr_i, ls_addr_i;
  logic [BW-1:0] ls_be_i;
  logic [DW-1:0] ls_wdata_i, mem_rdata_i;
  logic if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, mem_we_o, err_o, busy_o;
  logic [DW-1:0] if_rdata_o, ls_rdata_o, mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  always #5 clk = ~clk;
  simprisc_mem_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o), .busy_o(busy_o)
  );
  int checks = 0, passes = 0, cyc = 0;
  int m_ph = 0, m_own = 0, m_loss = 0, m_gcyc = 0;
  logic e_if_gnt, e_ls_gnt;
  int order[$];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask
  task automatic zero_in();
    if_req_i = 0; if_addr_i = '0; ls_req_i = 0; ls_we_i = 0; ls_be_i = '0; ls_addr_i = '0;
    ls_wdata_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask
  task automatic step();
    logic [6:0] ec;
    logic [DW-1:0] eird, elrd;
    logic [AW+DW+BW:0] epay;
    int np, k;
    #1;
    ec = '0; eird = '0; elrd = '0; epay = '0; np = m_ph;
    ec[0] = m_ph != 0;
    ec[1] = mem_rvalid_i && m_ph != 2;
    if (m_ph == 0 && (if_req_i || ls_req_i)) begin
      m_own  = ls_req_i && !(if_req_i && m_loss == MS) ? 1 : 0;
      m_loss = m_own == 0 ? 0 : if_req_i ? (m_loss < MS ? m_loss + 1 : MS) : m_loss;
      np = 1;
    end else if (m_ph == 1) begin
      ec[2] = 1'b1;
      epay = m_own == 1 ? {ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i} : {1'b0, {BW{1'b1}}, if_addr_i, {DW{1'b0}}};
      if (mem_gnt_i) begin
        ec[m_own == 1 ? 4 : 6] = 1'b1;
        m_gcyc = cyc;
        np = 2;
      end
    end else if (m_ph == 2) begin
      k = cyc - m_gcyc;
      if (mem_rvalid_i || k == TO) begin
        ec[m_own == 1 ? 3 : 5] = 1'b1;
        ec[1] = !mem_rvalid_i;
        if (m_own == 1) elrd = mem_rvalid_i ? mem_rdata_i : '0;
        else eird = mem_rvalid_i ? mem_rdata_i : '0;
        np = 0;
      end
    end
    chk("ctrl", {if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, err_o, busy_o}, ec);
    chk("if_rdata", if_rdata_o, eird);
    chk("ls_rdata", ls_rdata_o, elrd);
    chk("mem_payload", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, epay);
    if (if_gnt_o) order.push_back(0);
    if (ls_gnt_o) order.push_back(1);
    e_if_gnt = ec[6];
    e_ls_gnt = ec[4];
    m_ph = np;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input bit now);
    rst_n = 1'b0;
    zero_in();
    if (now) begin
      #1;
      chk("rst_async_busy", busy_o, 0);
      chk("rst_async_ctrl", {if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, err_o}, 0);
    end
    @(posedge clk);
    #1;
    chk("rst_ctrl", {if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, err_o, busy_o}, 0);
    chk("rst_data", {if_rdata_o, ls_rdata_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
    m_ph = 0; m_own = 0; m_loss = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic drain();
    if_req_i = 0; ls_req_i = 0; mem_gnt_i = 1;
    for (int i = 0; i < 100 && m_ph != 0; i++) begin
      mem_rvalid_i = m_ph == 2;
      step();
    end
    chk("drain_idle", m_ph, 0);
    mem_rvalid_i = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit if_p, ls_p, silent;
    zero_in();
    do_reset(0);
    // only IF: accept, grant, response 0x13
    if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
    step();
    step();
    if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    step();
    mem_rvalid_i = 0; mem_rdata_i = '0;
    step();
    // both held, zero-wait memory: IF must win every fifth arbitration
    order.delete();
    if_req_i = 1; if_addr_i = 32'h200; ls_req_i = 1; ls_addr_i = 32'h1000; ls_be_i = 4'hf;
    for (int i = 0; i < 40; i++) begin
      mem_rvalid_i = m_ph == 2;
      mem_rdata_i = $urandom;
      step();
    end
    for (int i = 0; i < 5 && m_ph != 2; i++) begin
      mem_rvalid_i = 0;
      step();
    end
    drain();
    chk("starve_cnt", order.size() >= 10, 1);
    for (int i = 0; i < 10 && i < order.size(); i++) chk("starve_order", order[i], i % 5 == 4 ? 0 : 1);
    // LS store
    ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'b0011; ls_addr_i = 32'h2000; ls_wdata_i = 32'hA5A5;
    mem_gnt_i = 1;
    step();
    step();
    ls_req_i = 0; mem_rvalid_i = 1;
    step();
    mem_rvalid_i = 0;
    step();
    // grant withheld for 10 ISSUE cycles
    ls_req_i = 1; ls_we_i = 0; ls_be_i = 4'hf; ls_addr_i = 32'h3000; ls_wdata_i = '0; mem_gnt_i = 0;
    step();
    repeat (10) step();
    mem_gnt_i = 1;
    step();
    drain();
    // response timeout, then a late response
    if_req_i = 1; if_addr_i = 32'h400; mem_gnt_i = 1;
    step();
    step();
    if_req_i = 0;
    repeat (TO) step();
    mem_rvalid_i = 1; mem_rdata_i = 32'hdead;
    step();
    mem_rvalid_i = 0;
    step();
    // reset mid-WAIT, then an in-flight response is stray
    ls_req_i = 1; ls_addr_i = 32'h5000; ls_be_i = 4'hf; mem_gnt_i = 1;
    step();
    step();
    ls_req_i = 0;
    step();
    step();
    do_reset(1);
    mem_rvalid_i = 1; mem_rdata_i = 32'hbeef;
    step();
    mem_rvalid_i = 0;
    step();
    // random traffic
    if_p = 0; ls_p = 0; silent = 0;
    for (int i = 0; i < 6000; i++) begin
      if (!if_p && $urandom_range(2) == 0) begin
        if_p = 1; if_addr_i = $urandom;
      end
      if (!ls_p && $urandom_range(2) == 0) begin
        ls_p = 1; ls_we_i = 1'($urandom); ls_be_i = 4'($urandom); ls_addr_i = $urandom; ls_wdata_i = $urandom;
      end
      if_req_i = if_p; ls_req_i = ls_p;
      mem_gnt_i = $urandom_range(2) != 0;
      mem_rvalid_i = m_ph == 2 ? !silent && $urandom_range(2) == 0 : $urandom_range(39) == 0;
      mem_rdata_i = $urandom;
      step();
      if (e_if_gnt) if_p = 0;
      if (e_ls_gnt) ls_p = 0;
      if (e_if_gnt || e_ls_gnt) silent = $urandom_range(15) == 0;
    end
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
